qtree_stream_loader: RTL and testbench

// - Parametrised host-side loader for dataflow QTree kernels: deserialises NUM_INPUTS postfix-encoded

---
 rtl/qtree_stream_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_qtree_stream_loader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtree_stream_loader.sv
// Host-side loader for dataflow QTree kernels: streams postfix trees into the heap, then launches.
// Optional malformed-stream detection is enabled by defining QTREE_ERR_EN.
module qtree_stream_loader #(
   parameter int unsigned NUM_INPUTS  = 2,
   parameter int unsigned PTR_W       = 16,
   parameter int unsigned VAL_W       = 32,
   parameter int unsigned STACK_DEPTH = 256,
   localparam int unsigned PL_W       = (VAL_W > 4 * PTR_W) ? VAL_W : 4 * PTR_W,
   localparam int unsigned TD_W       = PL_W + 2
) (
   input  logic                        clk,
   input  logic                        aresetn,
   input  logic [TD_W-1:0]             s_tdata,
   input  logic                        s_tvalid,
   input  logic                        s_tlast,
   output logic                        s_tready,
   output logic                        wr_valid,
   input  logic                        wr_ready,
   output logic [TD_W-1:0]             wr_data,
   input  logic                        ptr_valid,
   input  logic [PTR_W-1:0]            ptr_data,
   output logic                        go_valid,
   input  logic                        go_ready,
   output logic [NUM_INPUTS-1:0]       arg_valid,
   input  logic [NUM_INPUTS-1:0]       arg_ready,
   output logic [NUM_INPUTS*PTR_W-1:0] arg_data,
   input  logic                        res_valid,
   output logic                        res_ready,
   input  logic [VAL_W-1:0]            res_data,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic [VAL_W-1:0]            result_data,
   output logic                        busy,
   output logic                        err
);

   localparam int unsigned AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned SP_W = AW + 1;
   localparam int unsigned TI_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   localparam logic [1:0] TAG_NODE = 2'd2;

   localparam logic [2:0] ST_LOAD     = 3'd0;
   localparam logic [2:0] ST_ISSUE    = 3'd1;
   localparam logic [2:0] ST_WAIT_PTR = 3'd2;
   localparam logic [2:0] ST_LAUNCH   = 3'd3;
   localparam logic [2:0] ST_RUN      = 3'd4;
   localparam logic [2:0] ST_HOLD     = 3'd5;
`ifdef QTREE_ERR_EN
   localparam logic [2:0] ST_ERROR    = 3'd6;
`endif

   logic [2:0]            r_state, w_state_d;
   logic [SP_W-1:0]       r_sp;
   logic [TI_W-1:0]       r_tree_idx;
   logic [PTR_W-1:0]      r_stack [STACK_DEPTH];
   logic [PTR_W-1:0]      r_root [NUM_INPUTS];
   logic                  r_last;
   logic                  r_s_tready;
   logic                  r_wr_valid;
   logic [TD_W-1:0]       r_wr_data;
   logic                  r_go_valid;
   logic [NUM_INPUTS-1:0] r_arg_valid;
   logic                  r_result_valid;
   logic [VAL_W-1:0]      r_result_data;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_is_node;
   logic                  w_bad_beat;
   logic                  w_bad_ptr;
   logic                  w_launch_done;
   logic                  w_last_tree;
   logic [AW-1:0]         w_base;
   logic [PL_W-1:0]       w_pl;
   logic [TD_W-1:0]       w_beat;

   // s_tready is only ever high in LOAD, so it doubles as the state qualifier
   assign w_accept      = r_s_tready & s_tvalid;
   assign w_is_node     = (s_tdata[1:0] == TAG_NODE);
   assign w_base        = r_sp[AW-1:0] - AW'(4);
   assign w_last_tree   = (r_tree_idx == TI_W'(NUM_INPUTS - 1));
   assign w_launch_done = ((r_go_valid & ~go_ready) == 1'b0) &&
                          ((r_arg_valid & ~arg_ready) == '0);

   if (TD_W > VAL_W + 2) begin : g_unused
      logic w_unused_tdata;
      assign w_unused_tdata = ^s_tdata[TD_W-1:VAL_W+2];
   end

   always_comb begin
      w_pl = '0;
      if (w_is_node) begin
         for (int i = 0; i < 4; i++) begin
            w_pl[i*PTR_W +: PTR_W] = r_stack[w_base + AW'(i)];
         end
      end else begin
         w_pl[VAL_W-1:0] = s_tdata[VAL_W+1:2];
      end
      w_beat = {w_pl, s_tdata[1:0]};
   end

`ifdef QTREE_ERR_EN
   logic [SP_W-1:0] w_sp_after;
   assign w_sp_after = (w_is_node ? r_sp - SP_W'(4) : r_sp) + SP_W'(1);
   assign w_bad_beat = (w_is_node && (r_sp < SP_W'(4))) ||
                       (!w_is_node && (r_sp == SP_W'(STACK_DEPTH))) ||
                       (s_tlast && (w_sp_after != SP_W'(1)));
   assign w_bad_ptr  = ptr_valid && (r_state != ST_WAIT_PTR) && (r_state != ST_ERROR);
`else
   assign w_bad_beat = 1'b0;
   assign w_bad_ptr  = 1'b0;
`endif

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         ST_LOAD: begin
            if (w_accept) begin
`ifdef QTREE_ERR_EN
               w_state_d = w_bad_beat ? ST_ERROR : ST_ISSUE;
`else
               w_state_d = ST_ISSUE;
`endif
            end
         end
         ST_ISSUE:    if (wr_ready) w_state_d = ST_WAIT_PTR;
         ST_WAIT_PTR: begin
            if (ptr_valid) w_state_d = (r_last && w_last_tree) ? ST_LAUNCH : ST_LOAD;
         end
         ST_LAUNCH:   if (w_launch_done) w_state_d = ST_RUN;
         ST_RUN:      if (res_valid) w_state_d = ST_HOLD;
         ST_HOLD:     if (result_ready) w_state_d = ST_LOAD;
`ifdef QTREE_ERR_EN
         default:     w_state_d = ST_ERROR;
`else
         default:     w_state_d = ST_LOAD;
`endif
      endcase
`ifdef QTREE_ERR_EN
      if (w_bad_ptr) w_state_d = ST_ERROR;
`endif
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_state        <= ST_LOAD;
         r_sp           <= '0;
         r_tree_idx     <= '0;
         r_last         <= 1'b0;
         r_s_tready     <= 1'b0;
         r_wr_valid     <= 1'b0;
         r_wr_data      <= '0;
         r_go_valid     <= 1'b0;
         r_arg_valid    <= '0;
         r_result_valid <= 1'b0;
         r_result_data  <= '0;
         r_err          <= 1'b0;
         for (int i = 0; i < NUM_INPUTS; i++) r_root[i] <= '0;
      end else begin
         r_state        <= w_state_d;
         r_s_tready     <= (w_state_d == ST_LOAD);
         r_wr_valid     <= (w_state_d == ST_ISSUE);
         r_result_valid <= (w_state_d == ST_HOLD);
         if (w_bad_beat || w_bad_ptr) r_err <= 1'b1;

         // All launch valids rise together on entry, then fall one by one
         if (w_state_d != ST_LAUNCH) begin
            r_go_valid  <= 1'b0;
            r_arg_valid <= '0;
         end else if (r_state != ST_LAUNCH) begin
            r_go_valid  <= 1'b1;
            r_arg_valid <= '1;
         end else begin
            r_go_valid  <= r_go_valid & ~go_ready;
            r_arg_valid <= r_arg_valid & ~arg_ready;
         end

         if (w_accept && !w_bad_beat) begin
            r_wr_data <= w_beat;
            r_last    <= s_tlast;
            if (w_is_node) r_sp <= r_sp - SP_W'(4);
         end

         // A tree's final pointer is pushed and popped at once: it goes straight to the root
         if ((r_state == ST_WAIT_PTR) && ptr_valid) begin
            if (r_last) begin
               r_root[r_tree_idx] <= ptr_data;
               r_tree_idx         <= w_last_tree ? '0 : r_tree_idx + 1'b1;
            end else begin
               r_sp <= r_sp + SP_W'(1);
            end
         end

         if ((r_state == ST_RUN) && res_valid) r_result_data <= res_data;
      end
   end

   always_ff @(posedge clk) begin
      if ((r_state == ST_WAIT_PTR) && ptr_valid && !r_last) begin
         r_stack[r_sp[AW-1:0]] <= ptr_data;
      end
   end

   always_comb begin
      arg_data = '0;
      for (int i = 0; i < NUM_INPUTS; i++) arg_data[i*PTR_W +: PTR_W] = r_root[i];
   end

   assign s_tready     = r_s_tready;
   assign wr_valid     = r_wr_valid;
   assign wr_data      = r_wr_data;
   assign go_valid     = r_go_valid;
   assign arg_valid    = r_arg_valid;
   assign res_ready    = (r_state == ST_RUN);
   assign result_valid = r_result_valid;
   assign result_data  = r_result_data;
   assign busy         = !((r_state == ST_LOAD) && (r_sp == '0) && (r_tree_idx == '0));
`ifdef QTREE_ERR_EN
   assign err          = r_err;
`else
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_qtree_stream_loader.sv
// Directed bench for qtree_stream_loader (NUM_INPUTS=2, PTR_W=16, VAL_W=32).
module tb_qtree_stream_loader;

   localparam int unsigned NI    = 2;
   localparam int unsigned PTR_W = 16;
   localparam int unsigned VAL_W = 32;
   localparam int unsigned TD_W  = 66;

   logic                 clk = 1'b0;
   logic                 aresetn = 1'b0;
   logic [TD_W-1:0]      s_tdata = '0;
   logic                 s_tvalid = 1'b0;
   logic                 s_tlast = 1'b0;
   logic                 s_tready;
   logic                 wr_valid;
   logic                 wr_ready = 1'b0;
   logic [TD_W-1:0]      wr_data;
   logic                 ptr_valid = 1'b0;
   logic [PTR_W-1:0]     ptr_data = '0;
   logic                 go_valid;
   logic                 go_ready = 1'b0;
   logic [NI-1:0]        arg_valid;
   logic [NI-1:0]        arg_ready = '0;
   logic [NI*PTR_W-1:0]  arg_data;
   logic                 res_valid = 1'b0;
   logic                 res_ready;
   logic [VAL_W-1:0]     res_data = '0;
   logic                 result_valid;
   logic                 result_ready = 1'b0;
   logic [VAL_W-1:0]     result_data;
   logic                 busy;
   logic                 err;

   int total = 0;
   int bad = 0;
   logic [TD_W-1:0] seen_wr;

   qtree_stream_loader #(
      .NUM_INPUTS (NI),
      .PTR_W      (PTR_W),
      .VAL_W      (VAL_W),
      .STACK_DEPTH(256)
   ) dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tlast     (s_tlast),
      .s_tready    (s_tready),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .ptr_valid   (ptr_valid),
      .ptr_data    (ptr_data),
      .go_valid    (go_valid),
      .go_ready    (go_ready),
      .arg_valid   (arg_valid),
      .arg_ready   (arg_ready),
      .arg_data    (arg_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .result_data (result_data),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tready(input string name);
      int n = 0;
      tick();
      while (!s_tready && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (s_tready !== 1'b1) begin
         bad++;
         $display("FAIL %s_tready_timeout got=%b want=1", name, s_tready);
      end
   endtask

   // Full beat transfer with a zero-latency heap; captures the issued write
   task automatic send_beat(input logic [1:0] tag, input logic [31:0] val, input logic last,
                            input logic [15:0] ptr);
      wait_tready("send_beat");
      s_tvalid = 1'b1;
      s_tdata  = {32'd0, val, tag};
      s_tlast  = last;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      seen_wr  = wr_data;
      total++;
      if (wr_valid !== 1'b1) begin
         bad++;
         $display("FAIL send_beat_wr_valid got=%b want=1", wr_valid);
      end
      wr_ready = 1'b1;
      tick();
      wr_ready  = 1'b0;
      ptr_valid = 1'b1;
      ptr_data  = ptr;
      tick();
      ptr_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({s_tready, wr_valid, go_valid, arg_valid, result_valid, res_ready, busy, err} !== 9'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0", {s_tready, wr_valid, go_valid, arg_valid,
                  result_valid, res_ready, busy, err});
      end
      total++;
      if (result_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_result_data got=%h want=0", result_data);
      end
      aresetn = 1'b1;
      total++;
      if (s_tready !== 1'b0) begin
         bad++;
         $display("FAIL reset_tready_before_edge got=%b want=0", s_tready);
      end
      tick();
      total++;
      if (s_tready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_edge got tready=%b busy=%b want 1 0", s_tready, busy);
      end
   endtask

   task automatic test_single_trees();
      send_beat(2'd1, 32'd5, 1'b1, 16'h0010);
      total++;
      if (seen_wr !== 66'h15) begin
         bad++;
         $display("FAIL val5_wr_data got=%h want=15", seen_wr);
      end
      total++;
      if (busy !== 1'b1 || go_valid !== 1'b0) begin
         bad++;
         $display("FAIL tree0_done got busy=%b go=%b want 1 0", busy, go_valid);
      end
      send_beat(2'd1, 32'd7, 1'b1, 16'h0011);
      total++;
      if (seen_wr !== 66'h1d) begin
         bad++;
         $display("FAIL val7_wr_data got=%h want=1d", seen_wr);
      end
      total++;
      if (go_valid !== 1'b1 || arg_valid !== 2'b11 || arg_data !== 32'h0011_0010) begin
         bad++;
         $display("FAIL launch_entry got go=%b arg_v=%b arg=%h want 1 11 00110010",
                  go_valid, arg_valid, arg_data);
      end
   endtask

   task automatic test_launch_stagger();
      go_ready = 1'b1;
      tick();
      go_ready  = 1'b0;
      arg_ready = 2'b01;
      total++;
      if (go_valid !== 1'b0 || arg_valid !== 2'b11) begin
         bad++;
         $display("FAIL stagger_c2 got go=%b arg_v=%b want 0 11", go_valid, arg_valid);
      end
      tick();
      arg_ready = 2'b00;
      for (int c = 3; c <= 4; c++) begin
         total++;
         if (arg_valid !== 2'b10 || res_ready !== 1'b0 || arg_data !== 32'h0011_0010) begin
            bad++;
            $display("FAIL stagger_c%0d got arg_v=%b res_rdy=%b arg=%h want 10 0 00110010",
                     c, arg_valid, res_ready, arg_data);
         end
         tick();
      end
      arg_ready = 2'b10;
      total++;
      if (arg_valid !== 2'b10) begin
         bad++;
         $display("FAIL stagger_c5 got arg_v=%b want 10", arg_valid);
      end
      tick();
      arg_ready = 2'b00;
      total++;
      if (arg_valid !== 2'b00 || go_valid !== 1'b0 || res_ready !== 1'b1) begin
         bad++;
         $display("FAIL stagger_run got arg_v=%b go=%b res_rdy=%b want 00 0 1",
                  arg_valid, go_valid, res_ready);
      end
   endtask

   task automatic test_result_hold();
      res_valid = 1'b1;
      res_data  = 32'hDEADBEEF;
      tick();
      res_valid = 1'b0;
      res_data  = 32'h0;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (result_valid !== 1'b1 || result_data !== 32'hDEADBEEF || res_ready !== 1'b0) begin
            bad++;
            $display("FAIL result_hold_%0d got v=%b d=%h rr=%b want 1 deadbeef 0",
                     c, result_valid, result_data, res_ready);
         end
         tick();
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      total++;
      if (result_valid !== 1'b0 || result_data !== 32'hDEADBEEF || busy !== 1'b0 ||
          s_tready !== 1'b1) begin
         bad++;
         $display("FAIL result_consumed got v=%b d=%h busy=%b tready=%b want 0 deadbeef 0 1",
                  result_valid, result_data, busy, s_tready);
      end
   endtask

   task automatic test_node_tree();
      logic [TD_W-1:0] exp_node;
      exp_node = {64'h0004_0003_0002_0001, 2'b10};
      for (int i = 1; i <= 4; i++) send_beat(2'd1, 32'(i), 1'b0, 16'(i));
      send_beat(2'd2, 32'd0, 1'b1, 16'd5);
      total++;
      if (seen_wr !== exp_node) begin
         bad++;
         $display("FAIL node_wr_data got=%h want=%h", seen_wr, exp_node);
      end
      total++;
      if (busy !== 1'b1 || go_valid !== 1'b0 || s_tready !== 1'b1) begin
         bad++;
         $display("FAIL node_tree_done got busy=%b go=%b tready=%b want 1 0 1",
                  busy, go_valid, s_tready);
      end
   endtask

   task automatic test_issue_stall();
      logic [TD_W-1:0] exp_wr;
      exp_wr = {32'd0, 32'h0000_1234, 2'b01};
      wait_tready("stall");
      s_tvalid = 1'b1;
      s_tdata  = exp_wr;
      s_tlast  = 1'b1;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      for (int c = 0; c < 10; c++) begin
         total++;
         if (wr_valid !== 1'b1 || wr_data !== exp_wr || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL stall_%0d got v=%b d=%h tready=%b want 1 %h 0",
                     c, wr_valid, wr_data, s_tready, exp_wr);
         end
         tick();
      end
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      total++;
      if (wr_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_release got wr_valid=%b want 0", wr_valid);
      end
      ptr_valid = 1'b1;
      ptr_data  = 16'h0033;
      tick();
      ptr_valid = 1'b0;
      total++;
      if (go_valid !== 1'b1 || arg_valid !== 2'b11 || arg_data !== 32'h0033_0005) begin
         bad++;
         $display("FAIL stall_launch got go=%b arg_v=%b arg=%h want 1 11 00330005",
                  go_valid, arg_valid, arg_data);
      end
   endtask

   task automatic test_back_to_back();
      go_ready  = 1'b1;
      arg_ready = 2'b11;
      tick();
      go_ready  = 1'b0;
      arg_ready = 2'b00;
      total++;
      if (go_valid !== 1'b0 || arg_valid !== 2'b00 || res_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_run got go=%b arg_v=%b rr=%b want 0 00 1", go_valid, arg_valid, res_ready);
      end
      res_valid    = 1'b1;
      res_data     = 32'h1234_5678;
      result_ready = 1'b1;
      tick();
      res_valid = 1'b0;
      total++;
      if (result_valid !== 1'b1 || result_data !== 32'h1234_5678) begin
         bad++;
         $display("FAIL b2b_result got v=%b d=%h want 1 12345678", result_valid, result_data);
      end
      tick();
      result_ready = 1'b0;
      total++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_rearm got v=%b busy=%b want 0 0", result_valid, busy);
      end
   endtask

   task automatic test_midbatch_reset();
      send_beat(2'd1, 32'd9, 1'b0, 16'h0040);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL midbatch_busy got=%b want 1", busy);
      end
      aresetn = 1'b0;
      #2;
      total++;
      if (busy !== 1'b0 || s_tready !== 1'b0) begin
         bad++;
         $display("FAIL midbatch_in_reset got busy=%b tready=%b want 0 0", busy, s_tready);
      end
      aresetn = 1'b1;
      tick();
      total++;
      if (s_tready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL midbatch_after got tready=%b busy=%b want 1 0", s_tready, busy);
      end
      send_beat(2'd1, 32'd2, 1'b1, 16'h0050);
      send_beat(2'd1, 32'd3, 1'b1, 16'h0051);
      total++;
      if (go_valid !== 1'b1 || arg_data !== 32'h0051_0050) begin
         bad++;
         $display("FAIL midbatch_launch got go=%b arg=%h want 1 00510050", go_valid, arg_data);
      end
   endtask

`ifdef QTREE_ERR_EN
   task automatic test_err_node_empty();
      aresetn = 1'b0;
      #2;
      aresetn = 1'b1;
      wait_tready("err");
      s_tvalid = 1'b1;
      s_tdata  = {64'd0, 2'b10};
      s_tlast  = 1'b1;
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (err !== 1'b1 || wr_valid !== 1'b0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL err_node_%0d got err=%b wv=%b tready=%b want 1 0 0",
                     c, err, wr_valid, s_tready);
         end
         tick();
      end
      aresetn = 1'b0;
      #2;
      aresetn = 1'b1;
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL err_cleared got=%b want 0", err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_trees();
      test_launch_stagger();
      test_result_hold();
      test_node_tree();
      test_issue_stall();
      test_back_to_back();
      test_midbatch_reset();
`ifdef QTREE_ERR_EN
      test_err_node_empty();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=expired want=finished");
      $fatal(1, "watchdog");
   end

endmodule
